// File: rtl/fetch_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_issue_unit
// Description : Block fetch, word walk, decode and RS issue with branch/jump
//               resolution and in-block redirects.
// Revision    : 1.0
// ============================================================================
module fetch_issue_unit #(
  parameter int                   WORD_SIZE   = 32,
  parameter int                   BLOCK_WORDS = 32,
  parameter int                   REG_SIZE    = 6,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             icache_req_valid,
  output logic [WORD_SIZE-1:0]             icache_req_addr,
  input  logic                             icache_resp_valid,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] icache_resp_block,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output logic [2:0]                       iss_unit,
  output logic [REG_SIZE-1:0]              iss_reg1,
  output logic [REG_SIZE-1:0]              iss_reg2,
  output logic [REG_SIZE-1:0]              iss_reg3,
  output logic                             iss_hasimm,
  output logic [WORD_SIZE-1:0]             iss_imm,
  output logic                             br_req_valid,
  output logic [REG_SIZE-1:0]              br_reg1,
  output logic [REG_SIZE-1:0]              br_reg2,
  input  logic                             br_resp_valid,
  input  logic                             br_resp_taken,
  output logic [WORD_SIZE-1:0]             pc,
  output logic                             halted,
  output logic [31:0]                      issued_cnt
);

  localparam int c_IDX_W = $clog2(BLOCK_WORDS);
  localparam int c_OFF_W = c_IDX_W + 2;
  localparam int c_TAG_W = WORD_SIZE - c_OFF_W;

  localparam logic [1:0] c_ST_REQ     = 2'd0;
  localparam logic [1:0] c_ST_ISSUE   = 2'd1;
  localparam logic [1:0] c_ST_BR_WAIT = 2'd2;
  localparam logic [1:0] c_ST_HALT    = 2'd3;

  localparam logic [3:0] c_OP_HALT = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b1000;
  localparam logic [3:0] c_OP_MUL  = 4'b1001;
  localparam logic [3:0] c_OP_BGT  = 4'b1010;
  localparam logic [3:0] c_OP_LW   = 4'b1100;
  localparam logic [3:0] c_OP_SW   = 4'b1101;
  localparam logic [3:0] c_OP_JMP  = 4'b1110;
  localparam logic [3:0] c_OP_MV   = 4'b1111;

  localparam logic [WORD_SIZE-1:0] c_PC_STEP    = WORD_SIZE'(4);
  localparam logic [WORD_SIZE-1:0] c_ALIGN_MASK = {{(WORD_SIZE-2){1'b1}}, 2'b00};

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] w_pc_nxt;
  logic [WORD_SIZE-1:0] r_mem [BLOCK_WORDS];
  logic [c_TAG_W-1:0]   r_tag;
  logic                 r_blk_valid;
  logic [31:0]          r_issued_cnt;

  logic [c_IDX_W-1:0]   w_idx;
  logic [WORD_SIZE-1:0] w_inst;
  logic [3:0]           w_op;
  logic                 w_issuable;
  logic [2:0]           w_unit;
  logic [WORD_SIZE-1:0] w_imm;
  logic [WORD_SIZE-1:0] w_br_off;
  logic [WORD_SIZE-1:0] w_br_tgt;
  logic [WORD_SIZE-1:0] w_pc_inc;
  logic [WORD_SIZE-1:0] w_br_pc;
  logic                 w_inc_in_blk;
  logic                 w_tgt_in_blk;
  logic                 w_br_in_blk;
  logic                 w_issue_cand;
  logic                 w_fire;
  logic                 w_fill;

  // ---------------------------------------------------------------- decode
  assign w_idx  = r_pc[c_OFF_W-1:2];
  assign w_inst = r_mem[w_idx];
  assign w_op   = w_inst[31:28];

  always_comb begin
    w_issuable = 1'b1;
    w_unit     = 3'b000;
    case (w_op)
      c_OP_LW:  w_unit = 3'b000;
      c_OP_SW:  w_unit = 3'b001;
      c_OP_ADD: w_unit = 3'b010;
      c_OP_MUL: w_unit = 3'b011;
      c_OP_MV:  w_unit = 3'b100;
      default:  w_issuable = 1'b0;
    endcase
  end

  assign w_imm = (w_op == c_OP_MV) ? {{(WORD_SIZE-21){w_inst[21]}}, w_inst[21:1]}
                                   : {{(WORD_SIZE-15){w_inst[15]}}, w_inst[15:1]};

  // Branch and jump offsets are byte offsets from the branch's own pc.
  assign w_br_off = {{(WORD_SIZE-28){w_inst[27]}}, w_inst[27:0]};
  assign w_br_tgt = (r_pc + w_br_off) & c_ALIGN_MASK;
  assign w_pc_inc = r_pc + c_PC_STEP;
  assign w_br_pc  = br_resp_taken ? w_br_tgt : w_pc_inc;

  assign w_inc_in_blk = r_blk_valid && (w_pc_inc[WORD_SIZE-1:c_OFF_W] == r_tag);
  assign w_tgt_in_blk = r_blk_valid && (w_br_tgt[WORD_SIZE-1:c_OFF_W] == r_tag);
  assign w_br_in_blk  = r_blk_valid && (w_br_pc[WORD_SIZE-1:c_OFF_W] == r_tag);

  assign w_issue_cand = (r_state == c_ST_ISSUE) && r_blk_valid && w_issuable;
  assign w_fire       = w_issue_cand && iss_ready;
  assign w_fill       = (r_state == c_ST_REQ) && icache_resp_valid;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_REQ;
      r_pc         <= RESET_PC;
      r_tag        <= '0;
      r_blk_valid  <= 1'b0;
      r_issued_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_fill) begin
        r_tag       <= r_pc[WORD_SIZE-1:c_OFF_W];
        r_blk_valid <= 1'b1;
      end
      if (w_fire && (r_issued_cnt != '1)) begin
        r_issued_cnt <= r_issued_cnt + 32'd1;
      end
    end
  end

  // Block payload needs no reset; r_blk_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        r_mem[i] <= icache_resp_block[(BLOCK_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      c_ST_REQ: begin
        if (icache_resp_valid) begin
          w_state_nxt = c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        if (!r_blk_valid) begin
          w_state_nxt = c_ST_REQ;
        end else if (w_issuable) begin
          if (iss_ready) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = w_inc_in_blk ? c_ST_ISSUE : c_ST_REQ;
          end
        end else if (w_op == c_OP_JMP) begin
          w_pc_nxt    = w_br_tgt;
          w_state_nxt = w_tgt_in_blk ? c_ST_ISSUE : c_ST_REQ;
        end else if (w_op == c_OP_BGT) begin
          w_state_nxt = c_ST_BR_WAIT;
        end else if (w_op == c_OP_HALT) begin
          w_state_nxt = c_ST_HALT;
        end else begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = w_inc_in_blk ? c_ST_ISSUE : c_ST_REQ;
        end
      end
      c_ST_BR_WAIT: begin
        if (br_resp_valid) begin
          w_pc_nxt    = w_br_pc;
          w_state_nxt = w_br_in_blk ? c_ST_ISSUE : c_ST_REQ;
        end
      end
      c_ST_HALT: begin
        w_state_nxt = c_ST_HALT;
      end
      default: begin
        w_state_nxt = c_ST_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    icache_req_valid = 1'b0;
    icache_req_addr  = '0;
    iss_valid        = 1'b0;
    iss_unit         = 3'b000;
    iss_reg1         = '0;
    iss_reg2         = '0;
    iss_reg3         = '0;
    iss_hasimm       = 1'b0;
    iss_imm          = '0;
    br_req_valid     = 1'b0;
    br_reg1          = '0;
    br_reg2          = '0;
    halted           = 1'b0;
    case (r_state)
      c_ST_REQ: begin
        // REQ is the reset state, so the request is masked while reset is held.
        icache_req_valid = rst_n;
        icache_req_addr  = {r_pc[WORD_SIZE-1:c_OFF_W], {c_OFF_W{1'b0}}};
      end
      c_ST_ISSUE: begin
        if (w_issue_cand) begin
          iss_valid  = 1'b1;
          iss_unit   = w_unit;
          iss_reg1   = REG_SIZE'(w_inst[27:22]);
          iss_reg2   = REG_SIZE'(w_inst[21:16]);
          iss_reg3   = REG_SIZE'(w_inst[15:10]);
          iss_hasimm = w_inst[0];
          iss_imm    = w_imm;
        end
      end
      c_ST_BR_WAIT: begin
        br_req_valid = 1'b1;
        br_reg1      = REG_SIZE'(w_inst[27:22]);
        br_reg2      = REG_SIZE'(w_inst[21:16]);
      end
      c_ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  assign pc         = r_pc;
  assign issued_cnt = r_issued_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_issue_unit
// Description : Self-checking bench for fetch_issue_unit with an issue
//               scoreboard, decode vector table and multi-cycle sequences.
// Revision    : 1.0
// ============================================================================
module tb_fetch_issue_unit;

  localparam int WS = 32;
  localparam int BW = 32;
  localparam int RS = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            icache_req_valid;
  logic [WS-1:0]   icache_req_addr;
  logic            icache_resp_valid;
  logic [BW*WS-1:0] icache_resp_block;
  logic            iss_valid;
  logic            iss_ready;
  logic [2:0]      iss_unit;
  logic [RS-1:0]   iss_reg1, iss_reg2, iss_reg3;
  logic            iss_hasimm;
  logic [WS-1:0]   iss_imm;
  logic            br_req_valid;
  logic [RS-1:0]   br_reg1, br_reg2;
  logic            br_resp_valid;
  logic            br_resp_taken;
  logic [WS-1:0]   pc;
  logic            halted;
  logic [31:0]     issued_cnt;

  always #5 clk = ~clk;

  fetch_issue_unit #(.WORD_SIZE(WS), .BLOCK_WORDS(BW), .REG_SIZE(RS), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_block(icache_resp_block),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_unit(iss_unit),
    .iss_reg1(iss_reg1), .iss_reg2(iss_reg2), .iss_reg3(iss_reg3),
    .iss_hasimm(iss_hasimm), .iss_imm(iss_imm),
    .br_req_valid(br_req_valid), .br_reg1(br_reg1), .br_reg2(br_reg2),
    .br_resp_valid(br_resp_valid), .br_resp_taken(br_resp_taken),
    .pc(pc), .halted(halted), .issued_cnt(issued_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  unit;
    logic [5:0]  r1, r2, r3;
    logic        hasimm;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic        issuable;
    logic [2:0]  unit;
    logic [5:0]  r1, r2, r3;
    logic        hasimm;
    logic [31:0] imm;
  } vec_t;

  localparam logic [31:0] HALT_I = 32'h1000_0000;

  logic [31:0] mem [1024];
  exp_t        sb_q[$];
  logic [31:0] req_log[$];
  int          iss_cyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[11];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] e_imm(logic [3:0] op, logic [5:0] a, logic [5:0] b, logic [14:0] imm);
    return {op, a, b, imm, 1'b1};
  endfunction
  function automatic logic [31:0] e_reg(logic [3:0] op, logic [5:0] a, logic [5:0] b, logic [5:0] c);
    return {op, a, b, c, 10'd0};
  endfunction
  function automatic logic [31:0] e_mvi(logic [5:0] a, logic [20:0] imm);
    return {4'hF, a, imm, 1'b1};
  endfunction
  function automatic logic [31:0] e_br(logic [3:0] op, logic [27:0] off);
    return {op, off};
  endfunction

  task automatic push_exp(input logic [31:0] p, input logic [2:0] u, input logic [5:0] a,
                          input logic [5:0] b, input logic [5:0] c, input logic h, input logic [31:0] imm);
    exp_t e;
    e.pc = p; e.unit = u; e.r1 = a; e.r2 = b; e.r3 = c; e.hasimm = h; e.imm = imm;
    sb_q.push_back(e);
  endtask

  // Instruction cache model: answers every request in the cycle it is raised.
  initial begin
    int base;
    icache_resp_valid = 1'b0;
    icache_resp_block = '0;
    forever begin
      @(negedge clk);
      if (icache_req_valid) begin
        base = int'(icache_req_addr[11:2]);
        for (int i = 0; i < BW; i++) icache_resp_block[(BW-1-i)*WS +: WS] = mem[(base + i) % 1024];
        icache_resp_valid = 1'b1;
        req_log.push_back(icache_req_addr);
      end else begin
        icache_resp_valid = 1'b0;
      end
    end
  end

  // Issue monitor: every accepted issue is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && iss_valid && iss_ready) begin
        iss_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue actual_pc=%0h required=none", pc);
        end else begin
          e = sb_q.pop_front();
          check("iss_pc", pc, e.pc);
          check("iss_unit", 32'(iss_unit), 32'(e.unit));
          check("iss_reg1", 32'(iss_reg1), 32'(e.r1));
          check("iss_hasimm", 32'(iss_hasimm), 32'(e.hasimm));
          if (e.hasimm) check("iss_imm", iss_imm, e.imm);
          if (!e.hasimm || e.unit != 3'd4) check("iss_reg2", 32'(iss_reg2), 32'(e.r2));
          if (!e.hasimm) check("iss_reg3", 32'(iss_reg3), 32'(e.r3));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return iss_valid;
      1:       return br_req_valid;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(which) && n < max);
    check(name, 32'(sig(which)), 32'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    br_resp_valid = 1'b0;
    br_resp_taken = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    sb_q.delete();
    req_log.delete();
    iss_cyc.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_bgt(input logic [31:0] inst, input logic taken, input logic [5:0] er1,
                         input logic [5:0] er2, input logic [31:0] epc, input logic [31:0] eimm,
                         input logic [31:0] ehalt_pc);
    apply_reset();
    mem[0] = inst;
    mem[1] = e_imm(4'h8, 6'd1, 6'd1, 15'd11);
    mem[2] = HALT_I;
    mem[16] = e_imm(4'h8, 6'd1, 6'd1, 15'd22);
    mem[17] = HALT_I;
    push_exp(epc, 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, eimm);
    iss_ready = 1'b1;
    release_reset();
    wait_for("bgt_req_seen", 1, 20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bgt_req_held", 32'(br_req_valid), 32'd1);
      check("bgt_reg1", 32'(br_reg1), 32'(er1));
      check("bgt_reg2", 32'(br_reg2), 32'(er2));
      check("bgt_pc_hold", pc, 32'h0);
    end
    @(posedge clk); #1;
    br_resp_valid = 1'b1;
    br_resp_taken = taken;
    @(posedge clk); #1;
    br_resp_valid = 1'b0;
    wait_for("bgt_halt", 2, 40);
    check("bgt_halt_pc", pc, ehalt_pc);
    check("bgt_no_refetch", 32'(req_log.size()), 32'd1);
    check("bgt_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    iss_ready = 1'b0;
    br_resp_valid = 1'b0;
    br_resp_taken = 1'b0;

    // ---- reset state and the basic add/mv/halt program
    apply_reset();
    mem[0] = e_imm(4'h8, 6'd1, 6'd2, 15'd5);
    mem[1] = e_mvi(6'd3, 21'h1FFFFF);
    mem[2] = HALT_I;
    push_exp(32'd0, 3'd2, 6'd1, 6'd2, 6'd0, 1'b1, 32'd5);
    push_exp(32'd4, 3'd4, 6'd3, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rst_icache_req", 32'(icache_req_valid), 32'd0);
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_br_req", 32'(br_req_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_issued_cnt", issued_cnt, 32'd0);
    check("rst_pc", pc, 32'd0);
    iss_ready = 1'b1;
    release_reset();
    @(negedge clk);
    check("first_req_valid", 32'(icache_req_valid), 32'd1);
    check("first_req_addr", icache_req_addr, 32'd0);
    wait_for("basic_halt", 2, 50);
    check("basic_issued_cnt", issued_cnt, 32'd2);
    check("basic_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- decode vector table
    vecs[0]  = '{e_reg(4'h8, 6'd4, 6'd5, 6'd6), 1'b1, 3'd2, 6'd4, 6'd5, 6'd6, 1'b0, 32'd0};
    vecs[1]  = '{e_reg(4'h9, 6'd7, 6'd8, 6'd9), 1'b1, 3'd3, 6'd7, 6'd8, 6'd9, 1'b0, 32'd0};
    vecs[2]  = '{e_imm(4'hC, 6'd10, 6'd11, 15'h7FFD), 1'b1, 3'd0, 6'd10, 6'd11, 6'd0, 1'b1, 32'hFFFF_FFFD};
    vecs[3]  = '{e_imm(4'hD, 6'd12, 6'd13, 15'd100), 1'b1, 3'd1, 6'd12, 6'd13, 6'd0, 1'b1, 32'd100};
    vecs[4]  = '{e_reg(4'hF, 6'd14, 6'd15, 6'd0), 1'b1, 3'd4, 6'd14, 6'd15, 6'd0, 1'b0, 32'd0};
    vecs[5]  = '{e_mvi(6'd16, 21'h0FFFFF), 1'b1, 3'd4, 6'd16, 6'd0, 6'd0, 1'b1, 32'h000F_FFFF};
    vecs[6]  = '{32'h0000_0000, 1'b0, 3'd0, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0};
    vecs[7]  = '{32'hB000_0000, 1'b0, 3'd0, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0};
    vecs[8]  = '{e_imm(4'h8, 6'd1, 6'd1, 15'h4000), 1'b1, 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, 32'hFFFF_C000};
    vecs[9]  = '{32'h2000_0000, 1'b0, 3'd0, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0};
    vecs[10] = '{HALT_I, 1'b0, 3'd0, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      mem[i] = vecs[i].inst;
      if (vecs[i].issuable)
        push_exp(32'(4*i), vecs[i].unit, vecs[i].r1, vecs[i].r2, vecs[i].r3, vecs[i].hasimm, vecs[i].imm);
    end
    iss_ready = 1'b1;
    release_reset();
    wait_for("table_halt", 2, 60);
    check("table_issued_cnt", issued_cnt, 32'd7);
    check("table_halt_pc", pc, 32'd40);
    check("table_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- stall on iss_ready low
    apply_reset();
    mem[0] = e_reg(4'h9, 6'd1, 6'd2, 6'd3);
    mem[1] = HALT_I;
    push_exp(32'd0, 3'd3, 6'd1, 6'd2, 6'd3, 1'b0, 32'd0);
    iss_ready = 1'b0;
    release_reset();
    wait_for("stall_valid_seen", 0, 10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(iss_valid), 32'd1);
      check("stall_unit", 32'(iss_unit), 32'd3);
      check("stall_reg1", 32'(iss_reg1), 32'd1);
      check("stall_reg2", 32'(iss_reg2), 32'd2);
      check("stall_reg3", 32'(iss_reg3), 32'd3);
      check("stall_pc", pc, 32'd0);
    end
    @(posedge clk); #1;
    iss_ready = 1'b1;
    wait_for("stall_halt", 2, 20);
    check("stall_issued_cnt", issued_cnt, 32'd1);
    check("stall_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- full block throughput and boundary refetch
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = e_imm(4'h8, 6'd1, 6'd1, 15'(i));
      push_exp(32'(4*i), 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, 32'(i));
    end
    mem[32] = HALT_I;
    iss_ready = 1'b1;
    release_reset();
    wait_for("block_halt", 2, 200);
    check("block_issued_cnt", issued_cnt, 32'd32);
    check("block_issue_count", 32'(iss_cyc.size()), 32'd32);
    if (iss_cyc.size() == 32) check("block_issue_span", 32'(iss_cyc[31] - iss_cyc[0]), 32'd31);
    check("block_req_count", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) check("block_next_addr", req_log[1], 32'd128);
    check("block_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- jumps: in-block redirect and out-of-block refetch
    apply_reset();
    mem[0]  = e_imm(4'h8, 6'd1, 6'd1, 15'd1);
    mem[1]  = e_br(4'hE, 28'd8);
    mem[2]  = e_imm(4'h8, 6'd1, 6'd1, 15'd99);
    mem[3]  = e_imm(4'h8, 6'd1, 6'd1, 15'd3);
    mem[4]  = e_br(4'hE, 28'd244);
    mem[65] = e_imm(4'h8, 6'd1, 6'd1, 15'd65);
    mem[66] = HALT_I;
    push_exp(32'd0, 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, 32'd1);
    push_exp(32'd12, 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, 32'd3);
    push_exp(32'd260, 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, 32'd65);
    iss_ready = 1'b1;
    release_reset();
    wait_for("jmp_halt", 2, 60);
    check("jmp_issued_cnt", issued_cnt, 32'd3);
    check("jmp_halt_pc", pc, 32'd264);
    check("jmp_req_count", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) check("jmp_far_addr", req_log[1], 32'd256);
    check("jmp_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- bgt taken (offset 64) and not taken (operands 5,9)
    run_bgt(e_br(4'hA, 28'd64), 1'b1, 6'd0, 6'd0, 32'd64, 32'd22, 32'd68);
    run_bgt({4'hA, 6'd5, 6'd9, 16'd64}, 1'b0, 6'd5, 6'd9, 32'd4, 32'd11, 32'd8);

    // ---- reset while waiting on a branch compare
    apply_reset();
    mem[0] = e_imm(4'h8, 6'd1, 6'd1, 15'd1);
    mem[1] = e_br(4'hA, 28'd64);
    push_exp(32'd0, 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, 32'd1);
    iss_ready = 1'b1;
    release_reset();
    wait_for("rbr_req_seen", 1, 20);
    check("rbr_cnt_before", issued_cnt, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rbr_br_req", 32'(br_req_valid), 32'd0);
    check("rbr_iss_valid", 32'(iss_valid), 32'd0);
    check("rbr_icache_req", 32'(icache_req_valid), 32'd0);
    check("rbr_issued_cnt", issued_cnt, 32'd0);
    check("rbr_pc", pc, 32'd0);
    req_log.delete();
    push_exp(32'd0, 3'd2, 6'd1, 6'd1, 6'd0, 1'b1, 32'd1);
    release_reset();
    @(negedge clk);
    check("rbr_restart_req", 32'(icache_req_valid), 32'd1);
    check("rbr_restart_addr", icache_req_addr, 32'd0);
    wait_for("rbr_req_again", 1, 20);
    check("rbr_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- reset while an issue waits for iss_ready
    apply_reset();
    mem[0] = e_reg(4'h9, 6'd1, 6'd2, 6'd3);
    iss_ready = 1'b0;
    release_reset();
    wait_for("riss_valid_seen", 0, 10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("riss_iss_valid", 32'(iss_valid), 32'd0);
    check("riss_icache_req", 32'(icache_req_valid), 32'd0);
    check("riss_pc", pc, 32'd0);
    release_reset();
    wait_for("riss_valid_again", 0, 10);
    check("riss_pc_again", pc, 32'd0);
    check("riss_issued_cnt", issued_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
